// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single memory port between instruction fetch (imem) and
// load/store (dmem). One request is granted per cycle; the owner of every
// accepted request is pushed into an in-order tag FIFO, and each in-order
// memory response is steered back to the requester at the FIFO head.
//
// Optional feature macro:
//   MEM_ARB_ROUND_ROBIN_EN  - defined: round-robin arbitration with a 1-bit
//                             preferred-requester pointer.
//                             undefined: fixed priority, dmem over imem.
//
// Bundle layouts (packed, MSB first):
//   Bundle::MemoryIn  [69:0] = { req[68:0], req_valid }
//   Bundle::MemoryOut [33:0] = { res[31:0], req_ready, res_valid }
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   imem_in   in  70  MemoryIn from fetch
//   imem_out  out 34  MemoryOut to fetch
//   dmem_in   in  70  MemoryIn from load/store
//   dmem_out  out 34  MemoryOut to load/store
//   mem_in    out 70  MemoryIn to memory
//   mem_out   in  34  MemoryOut from memory
//   busy      out  1  tag FIFO non-empty
//   err       out  1  sticky: response arrived with nothing outstanding
//
// Parameter:
//   OUTSTANDING  maximum accepted-but-unanswered requests (1..4, default 2)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [69:0] imem_in,
    output logic [33:0] imem_out,
    input  logic [69:0] dmem_in,
    output logic [33:0] dmem_out,
    output logic [69:0] mem_in,
    input  logic [33:0] mem_out,
    output logic        busy,
    output logic        err
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

    // Owner tag encoding.
    localparam logic OWN_IMEM = 1'b0;
    localparam logic OWN_DMEM = 1'b1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Bundle unpacking
    // -------------------------------------------------------------------------
    logic [68:0] i_req;
    logic        i_vld;
    logic [68:0] d_req;
    logic        d_vld;
    logic [31:0] m_res;
    logic        m_ready;
    logic        m_res_vld;

    assign i_req     = imem_in[69:1];
    assign i_vld     = imem_in[0];
    assign d_req     = dmem_in[69:1];
    assign d_vld     = dmem_in[0];
    assign m_res     = mem_out[33:2];
    assign m_ready   = mem_out[1];
    assign m_res_vld = mem_out[0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic                   lock_owner_q, lock_owner_d;
    logic [OUTSTANDING-1:0] tags_q, tags_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    // Preferred requester under contention.
    logic pref;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    assign pref = rr_q;
`else
    assign pref = OWN_DMEM;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    logic full;
    logic lock_hold;
    logic gnt_valid;
    logic gnt_owner;
    logic accept;

    assign full = (cnt_q == CNT_FULL);

    // The lock only binds while its owner keeps requesting; if the owner
    // drops req_valid the arbiter falls back to open arbitration this cycle.
    assign lock_hold = (state_q == ST_LOCKED) &&
                       ((lock_owner_q == OWN_DMEM) ? d_vld : i_vld);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = pref;
        if (lock_hold) begin
            gnt_valid = 1'b1;
            gnt_owner = lock_owner_q;
        end else if (i_vld && d_vld) begin
            gnt_valid = 1'b1;
            gnt_owner = pref;
        end else if (d_vld) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_DMEM;
        end else if (i_vld) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_IMEM;
        end
        // A full FIFO blocks every grant, even when a response is popping
        // this cycle; the freed slot is only usable next cycle.
        if (full || !rst_n) begin
            gnt_valid = 1'b0;
        end
    end

    assign accept = gnt_valid && m_ready;

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    logic pop;
    logic resp_owner;
    logic stray_resp;

    assign resp_owner = tags_q[rd_ptr_q];
    assign pop        = rst_n && m_res_vld && (cnt_q != '0);
    assign stray_resp = rst_n && m_res_vld && (cnt_q == '0);

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_in = {(gnt_owner == OWN_DMEM) ? d_req : i_req, gnt_valid};

    assign imem_out = {m_res,
                       accept && (gnt_owner == OWN_IMEM),
                       pop && (resp_owner == OWN_IMEM)};

    assign dmem_out = {m_res,
                       accept && (gnt_owner == OWN_DMEM),
                       pop && (resp_owner == OWN_DMEM)};

    assign busy = (cnt_q != '0);
    assign err  = err_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        if (gnt_valid && !m_ready) begin
            state_d      = ST_LOCKED;
            lock_owner_d = gnt_owner;
        end else if (gnt_valid) begin
            state_d = ST_OPEN;
        end else if (!lock_hold) begin
            state_d = ST_OPEN;
        end
    end

    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            tags_d[wr_ptr_q] = gnt_owner;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign err_d = err_q || stray_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // After an acceptance the other requester becomes preferred.
    assign rr_d = accept ? ~gnt_owner : rr_q;
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OPEN;
            lock_owner_q <= OWN_IMEM;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q         <= OWN_DMEM;
`endif
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`endif
        end
    end

    // Tag storage is qualified by the count, so it needs no reset.
    always_ff @(posedge clk) begin
        tags_q <= tags_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [69:0] imem_in, dmem_in, mem_in;
    logic [33:0] imem_out, dmem_out, mem_out;
    logic        busy, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out),
        .busy     (busy),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of owners (0 = imem, 1 = dmem) of outstanding
    // requests, lock flag/owner, preferred requester, sticky error.
    bit owners[$];
    bit m_locked, m_lock_own, m_pref, m_err;

    logic [68:0] i_req, d_req;
    logic        o_i_rdy, o_d_rdy, o_i_rv, o_d_rv;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        m_locked   = 1'b0;
        m_lock_own = 1'b0;
        m_pref     = 1'b1;
        m_err      = 1'b0;
    endtask

    // One clock cycle: drive, check combinational outputs against the model,
    // clock, then advance the model.
    task automatic step(input bit iv, input bit dv, input bit rdy, input bit rv,
                        input logic [31:0] rdata);
        bit full, g, own, do_pop, pop_own;
        imem_in = {i_req, iv};
        dmem_in = {d_req, dv};
        mem_out = {rdata, rdy, rv};
        #1;
        full = (owners.size() == OUT);
        g    = 1'b0;
        own  = 1'b0;
        if (!full) begin
            if (m_locked && (m_lock_own ? dv : iv)) begin g = 1'b1; own = m_lock_own; end
            else if (iv && dv) begin g = 1'b1; own = m_pref; end
            else if (dv)       begin g = 1'b1; own = 1'b1; end
            else if (iv)       begin g = 1'b1; own = 1'b0; end
        end
        do_pop  = rv && (owners.size() > 0);
        pop_own = do_pop ? owners[0] : 1'b0;

        chk("mem_req_valid", 70'(mem_in[0]), 70'(g));
        if (g) chk("mem_req", 70'(mem_in[69:1]), 70'(own ? d_req : i_req));
        chk("imem_req_ready", 70'(imem_out[1]), 70'(g && !own && rdy));
        chk("dmem_req_ready", 70'(dmem_out[1]), 70'(g && own && rdy));
        chk("imem_res_valid", 70'(imem_out[0]), 70'(do_pop && !pop_own));
        chk("dmem_res_valid", 70'(dmem_out[0]), 70'(do_pop && pop_own));
        chk("imem_res", 70'(imem_out[33:2]), 70'(rdata));
        chk("dmem_res", 70'(dmem_out[33:2]), 70'(rdata));
        chk("busy", 70'(busy), 70'(owners.size() > 0));
        chk("err", 70'(err), 70'(m_err));

        o_i_rdy = imem_out[1];
        o_d_rdy = dmem_out[1];
        o_i_rv  = imem_out[0];
        o_d_rv  = dmem_out[0];

        @(posedge clk);
        if (rv) begin
            if (owners.size() > 0) void'(owners.pop_front());
            else m_err = 1'b1;
        end
        if (g && rdy) begin
            owners.push_back(own);
            m_locked = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_pref = ~own;
`endif
        end else if (g) begin
            m_locked   = 1'b1;
            m_lock_own = own;
        end else if (m_locked && !(m_lock_own ? dv : iv)) begin
            m_locked = 1'b0;
        end
        #1;
    endtask

    task automatic rand_reqs();
        i_req = {5'($urandom), $urandom, $urandom};
        d_req = {5'($urandom), $urandom, $urandom};
    endtask

    initial begin
        bit iv, dv, rdy, rv;

        // Reset state: outputs forced low even with valid inputs.
        rst_n   = 1'b0;
        i_req   = '0;
        d_req   = '0;
        imem_in = {69'd0, 1'b1};
        dmem_in = {69'd0, 1'b1};
        mem_out = {32'hA5A5_A5A5, 1'b1, 1'b1};
        model_reset();
        #3;
        chk("rst_mem_req_valid", 70'(mem_in[0]), 70'd0);
        chk("rst_imem_ctl", 70'(imem_out[1:0]), 70'd0);
        chk("rst_dmem_ctl", 70'(dmem_out[1:0]), 70'd0);
        chk("rst_busy", 70'(busy), 70'd0);
        chk("rst_err", 70'(err), 70'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single imem load.
        i_req = 69'h100;
        step(1, 0, 1, 0, 32'h0);
        chk("load_i_rdy", 70'(o_i_rdy), 70'd1);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("load_i_rv", 70'(o_i_rv), 70'd1);
        chk("load_d_rv", 70'(o_d_rv), 70'd0);
        chk("load_busy_after", 70'(busy), 70'd0);

        // Contention, responses keep the FIFO from filling.
        for (int k = 0; k < 4; k++) begin
            rand_reqs();
            step(1, 1, 1, k > 0, 32'(k));
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("cont_d_rdy", 70'(o_d_rdy), 70'(k % 2 == 0));
            chk("cont_i_rdy", 70'(o_i_rdy), 70'(k % 2 == 1));
`else
            chk("cont_d_rdy", 70'(o_d_rdy), 70'd1);
            chk("cont_i_rdy", 70'(o_i_rdy), 70'd0);
`endif
        end
        step(0, 0, 1, 1, 32'h5);

        // Lock: imem stalls, dmem arrives, imem still accepted first.
        rand_reqs();
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        chk("lock_d_rdy_stall", 70'(o_d_rdy), 70'd0);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("lock_i_rdy", 70'(o_i_rdy), 70'd1);
        chk("lock_d_rdy", 70'(o_d_rdy), 70'd0);
        step(0, 1, 1, 0, 32'h0);
        chk("lock_d_next", 70'(o_d_rdy), 70'd1);
        step(0, 0, 1, 1, 32'h1);
        step(0, 0, 1, 1, 32'h2);

        // Full FIFO.
        step(1, 0, 1, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        chk("full_i_rdy", 70'(o_i_rdy), 70'd0);
        step(1, 0, 1, 1, 32'h33);
        chk("full_pop_i_rdy", 70'(o_i_rdy), 70'd0);
        step(1, 0, 1, 0, 32'h0);
        chk("full_after_i_rdy", 70'(o_i_rdy), 70'd1);
        step(0, 0, 1, 1, 32'h3);
        step(0, 0, 1, 1, 32'h4);

        // Interleaved order with push and pop in the same cycle.
        step(0, 1, 1, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h11);
        chk("order_d_rv", 70'(o_d_rv), 70'd1);
        chk("order_i_rv0", 70'(o_i_rv), 70'd0);
        step(1, 0, 1, 1, 32'h22);
        chk("order_i_rv", 70'(o_i_rv), 70'd1);
        chk("pushpop_busy", 70'(busy), 70'd1);
        step(0, 0, 1, 1, 32'h33);
        chk("order_busy_end", 70'(busy), 70'd0);

        // Stray response sets err; mid-flight reset clears everything.
        step(0, 0, 1, 1, 32'h44);
        chk("stray_i_rv", 70'(o_i_rv), 70'd0);
        chk("stray_err", 70'(err), 70'd1);
        step(1, 0, 1, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_err", 70'(err), 70'd0);
        chk("midrst_busy", 70'(busy), 70'd0);
        chk("midrst_mem_valid", 70'(mem_in[0]), 70'd0);
        chk("midrst_i_rdy", 70'(imem_out[1]), 70'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 1, 32'h55);
        chk("postrst_err", 70'(err), 70'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_reqs();
            iv  = 1'($urandom);
            dv  = 1'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (owners.size() > 0) && 1'($urandom);
            step(iv, dv, rdy, rv, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (imem) and load/store (dmem). It grants one request per cycle to the memory, records the owner of each accepted request in an in-order tag FIFO, and steers each in-order memory response back to the requester that issued it. It sits between the fetch/execute stages and the memory model, and speaks `Bundle::MemoryIn` / `Bundle::MemoryOut` on all three sides.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered requests, legal range 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_in` in 70: `Bundle::MemoryIn` from fetch, carrying `req` and `req_valid`.
- `imem_out` out 34: `Bundle::MemoryOut` to fetch, carrying `res`, `req_ready` and `res_valid`.
- `dmem_in` in 70: `Bundle::MemoryIn` from load/store.
- `dmem_out` out 34: `Bundle::MemoryOut` to load/store.
- `mem_in` out 70: `Bundle::MemoryIn` to memory.
- `mem_out` in 34: `Bundle::MemoryOut` from memory.
- `busy` out 1: tag FIFO is non-empty.
- `err` out 1: sticky flag. Set when a response arrives while nothing is outstanding.

## Operation
- **Accept:** a request is accepted when `mem_in.req_valid && mem_out.req_ready`. On acceptance the arbiter pushes an owner tag (0 = imem, 1 = dmem) into the tag FIFO.
- **Grant choice:**
  - Candidates are the requesters whose `req_valid` = 1.
  - No grant is made while the FIFO is full (count == `OUTSTANDING`).
  - Default policy is fixed priority, dmem over imem.
- **Lock state:** the arbiter has two states, `OPEN` and `LOCKED`.
  - `OPEN` → `LOCKED` when a grant is presented but memory does not accept it (`req_ready` = 0). The locked owner is recorded.
  - In `LOCKED`, the grant stays with the locked owner regardless of priority, until acceptance, then → `OPEN`.
  - If the locked owner drops `req_valid`, the state → `OPEN` in the same cycle.
- **Request forwarding (combinational):**
  - `mem_in.req` = granted requester's `req`. When there is no grant it is that requester's `req` anyway (don't-care).
  - `mem_in.req_valid` = grant exists.
- **Ready:** `x_out.req_ready` = (x is granted) && `mem_out.req_ready`. The ungranted requester sees `req_ready` = 0.
- **Response routing:**
  - `mem_out.res` is broadcast to both requesters.
  - On `mem_out.res_valid`, the arbiter pops the FIFO head and asserts `res_valid` only on that owner's `_out`; the other requester's `res_valid` is 0.
- **Boundary conditions:**
  - Push and pop in the same cycle: count is unchanged and the head advances.
  - Response with an empty FIFO: dropped, no `res_valid` to either requester, `err` ← 1.
  - Full FIFO: both `req_ready` = 0 and `mem_in.req_valid` = 0, even with a response popping in the same cycle. The freed slot becomes usable next cycle.
  - FIFO pointers are `$clog2(OUTSTANDING)`-bit wide (minimum 1) and wrap modulo `OUTSTANDING`. Count is `$clog2(OUTSTANDING+1)` bits.

## Timing
- Request path is zero-latency: the grant, `mem_in` and `req_ready` are combinational from the `_in` ports, the lock state and the FIFO count.
- Memory returns responses in order, at the earliest one cycle after acceptance. A response to a request accepted in the same cycle is illegal.
- Response path is zero-latency: `res_valid` routing is combinational from `mem_out.res_valid` and the registered FIFO head.
- Reset (asynchronous, while `rst_n` = 0):
  - FIFO empty; pointers and count = 0.
  - State = `OPEN`; `err` = 0; `busy` = 0; round-robin pointer = dmem-preferred.
  - `mem_in.req_valid`, both `req_ready` and both `res_valid` are forced to 0.
- Reset in mid-operation discards all outstanding tags. Responses arriving after reset release set `err`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Policy is round-robin, with a 1-bit pointer naming the preferred requester.
  - On each acceptance, the pointer moves to the non-accepted requester.
  - Under contention, the grant goes to the pointer's requester.
  - The lock still overrides.
- Undefined: fixed dmem-over-imem priority. No pointer register exists.

## Test plan
- **Single imem load:** imem `req_valid`=1, addr 0x100, `mem req_ready`=1, response 0xDEADBEEF two cycles later → imem `res_valid`=1 with data 0xDEADBEEF; dmem `res_valid`=0; `busy` 1→0.
- **Contention:** both valid every cycle, `req_ready`=1.
  - Fixed priority: dmem accepted 4 cycles in a row, imem `req_ready`=0.
  - `MEM_ARB_ROUND_ROBIN_EN`: acceptance order d, i, d, i.
- **Lock:** imem valid alone, `req_ready`=0 for 3 cycles. dmem raises valid in cycle 2, then `req_ready`=1 → imem is accepted first and dmem in the next cycle.
- **Full FIFO:** `OUTSTANDING`=2, two accepts, no responses → third request sees `req_ready`=0. A response arrives → the third request is accepted the following cycle.
- **Interleaved order:** accepts d then i; responses 0x11 and 0x22 on consecutive cycles → dmem gets 0x11, imem gets 0x22. Push and pop in the same cycle leaves the count correct.
- **Error and reset:** `res_valid` with an empty FIFO → no requester `res_valid`, `err`=1. Assert `rst_n`=0 mid-flight → `err`=0, `busy`=0 immediately.
